// File: rtl/pll_sup_pkg.sv
// -----------------------------------------------------------------------------
// pll_sup_pkg
// Shared types and constants for the PLL lock supervisor.
//   sup_state_t : supervisor sequencing states
//   RELOCK_W    : width of the saturating relock event counter
//   RETRY_W     : width of the consecutive-failed-attempt counter
//   cnt_width() : width of the shared cycle counter, sized to the largest
//                 cycle parameter
// -----------------------------------------------------------------------------
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } sup_state_t;

  localparam int RELOCK_W = 8;
  localparam int RETRY_W  = 8;

  // The counter only ever has to hold (param - 1), so clog2 of the largest
  // parameter is enough. Clamp to one bit for degenerate values.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pll_sup_sync2.sv
// -----------------------------------------------------------------------------
// pll_sup_sync2
// Two-flop synchroniser for a single asynchronous level, synchronous
// active-low reset to 0.
//   clk   in  sampling clock
//   rst_n in  synchronous active-low reset
//   d     in  asynchronous input level
//   q     out synchronised level (2 cycles of latency)
// -----------------------------------------------------------------------------
module pll_sup_sync2
  import pll_sup_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
// Sequences the reset of a PLL clock wrapper, qualifies its lock output,
// holds PLL-clocked logic in reset until lock is stable and re-locks
// automatically on loss of lock. Clocked by the free-running oscillator.
//
// Ports:
//   sys_clk      in   oscillator clock, rising edge
//   sys_rst_n    in   synchronous active-low reset
//   pll_lock     in   PLL lock, asynchronous to sys_clk
//   force_relock in   single-cycle request to reset and re-lock the PLL
//   pll_rst      out  active-high PLL reset
//   user_rst_n   out  active-low reset for PLL-clocked logic
//   pll_ready    out  high only while running
//   fault        out  sticky, high after too many failed lock attempts
//   relock_cnt   out  saturating count of lock-loss / force events
//
// Optional feature (macro PLL_SUP_GLITCH_FILTER_EN): while running, lock must
// be low for GLITCH_CYC consecutive cycles before loss of lock is declared.
// Without the macro a single low cycle of the synchronised lock is a loss.
// -----------------------------------------------------------------------------
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 100000,
  parameter int MAX_RETRY        = 8,
  parameter int GLITCH_CYC       = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                pll_lock,
  input  logic                force_relock,
  output logic                pll_rst,
  output logic                user_rst_n,
  output logic                pll_ready,
  output logic                fault,
  output logic [RELOCK_W-1:0] relock_cnt
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

  sup_state_t            state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [RETRY_W-1:0]    retry, retry_n;
  logic [RELOCK_W-1:0]   relock_n;
  logic                  lock_s;
  logic                  lock_lost;

  pll_sup_sync2 u_lock_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

`ifdef PLL_SUP_GLITCH_FILTER_EN
  localparam logic [CNT_W-1:0] GLITCH_LAST = CNT_W'(GLITCH_CYC - 1);
`else
  logic unused_glitch;
  assign unused_glitch = (GLITCH_CYC != 0);
`endif

  // Outputs are registered from the next state so they line up with the
  // state register: e.g. pll_ready is already high on the first RUN cycle.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= RESET_PLL;
      cnt        <= '0;
      retry      <= '0;
      relock_cnt <= '0;
      pll_rst    <= 1'b1;
      user_rst_n <= 1'b0;
      pll_ready  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      retry      <= retry_n;
      relock_cnt <= relock_n;
      pll_rst    <= (state_n == RESET_PLL) || (state_n == FAULT);
      user_rst_n <= (state_n == RUN);
      pll_ready  <= (state_n == RUN);
      fault      <= (state_n == FAULT);
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    retry_n   = retry;
    relock_n  = relock_cnt;
    lock_lost = 1'b0;

    unique case (state)
      RESET_PLL: begin
        if (force_relock) begin
          cnt_n = '0;
        end else if (cnt == RST_LAST) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      WAIT_LOCK: begin
        if (force_relock) begin
          state_n = RESET_PLL;
          cnt_n   = '0;
        end else if (lock_s) begin
          state_n = STABLE;
          cnt_n   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          // retry is compared after the increment: MAX_RETRY failed
          // attempts in a row end in FAULT.
          retry_n = retry + RETRY_W'(1);
          cnt_n   = '0;
          state_n = (retry_n == RETRY_LIMIT) ? FAULT : RESET_PLL;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      STABLE: begin
        if (force_relock) begin
          state_n = RESET_PLL;
          cnt_n   = '0;
        end else if (!lock_s) begin
          // Lock dropped before qualifying: wait again with a fresh
          // timeout; this is not counted as a failed attempt.
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_n = RUN;
          cnt_n   = '0;
          retry_n = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      RUN: begin
`ifdef PLL_SUP_GLITCH_FILTER_EN
        // The shared counter tracks consecutive low cycles of lock_s here.
        if (lock_s) begin
          cnt_n = '0;
        end else if (cnt == GLITCH_LAST) begin
          lock_lost = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
`else
        lock_lost = ~lock_s;
`endif
        // A coincident loss and force count as a single event.
        if (force_relock || lock_lost) begin
          state_n = RESET_PLL;
          cnt_n   = '0;
          if (relock_cnt != {RELOCK_W{1'b1}}) relock_n = relock_cnt + RELOCK_W'(1);
        end
      end

      FAULT: begin
        state_n = FAULT;
      end

      default: begin
        state_n = RESET_PLL;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_supervisor
// Directed bench for pll_lock_supervisor with shortened cycle parameters.
// A phase/age model of the lock sequence predicts all outputs every cycle;
// directed steps add literal expectations for pulse widths, latencies and
// counter values. Honours PLL_SUP_GLITCH_FILTER_EN when defined.
// -----------------------------------------------------------------------------
module tb_pll_lock_supervisor;

  localparam int RP = 16;   // reset pulse cycles
  localparam int LS = 32;   // lock-stable cycles
  localparam int LT = 300;  // lock timeout cycles
  localparam int MR = 4;    // failed attempts before fault
  localparam int GC = 4;    // glitch filter length

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst, user_rst_n, pll_ready, fault;
  logic [7:0] relock_cnt;

  int checks = 0;
  int errors = 0;

  pll_lock_supervisor #(
    .RST_PULSE_CYC    (RP),
    .LOCK_STABLE_CYC  (LS),
    .LOCK_TIMEOUT_CYC (LT),
    .MAX_RETRY        (MR),
    .GLITCH_CYC       (GC)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .pll_lock     (pll_lock),
    .force_relock (force_relock),
    .pll_rst      (pll_rst),
    .user_rst_n   (user_rst_n),
    .pll_ready    (pll_ready),
    .fault        (fault),
    .relock_cnt   (relock_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the supervisor is in one phase of a lock attempt and
  // has spent 'age' cycles in it. Decisions see pll_lock two cycles late.
  // ---------------------------------------------------------------------------
  localparam int PH_PULSE = 0, PH_WAIT = 1, PH_QUAL = 2, PH_RUN = 3, PH_DEAD = 4;

  int         ph = PH_PULSE;
  int         age = 0;
  int         fails = 0;
  int         events = 0;
  int         low_run = 0;
  logic [1:0] lock_pipe = 2'b00;
  bit         model_live = 1'b0;

  task automatic go(input int p);
    ph      = p;
    age     = 0;
    low_run = 0;
  endtask

  task automatic model_step();
    logic seen;
    bit   lost;
    seen      = lock_pipe[1];
    lock_pipe = {lock_pipe[0], pll_lock};
    if (!sys_rst_n) begin
      go(PH_PULSE);
      fails     = 0;
      events    = 0;
      lock_pipe = 2'b00;
      return;
    end
    case (ph)
      PH_PULSE: begin
        if (force_relock)       go(PH_PULSE);
        else if (age + 1 == RP) go(PH_WAIT);
        else                    age++;
      end
      PH_WAIT: begin
        if (force_relock)       go(PH_PULSE);
        else if (seen)          go(PH_QUAL);
        else if (age + 1 == LT) begin
          fails++;
          go(fails >= MR ? PH_DEAD : PH_PULSE);
        end else                age++;
      end
      PH_QUAL: begin
        if (force_relock)       go(PH_PULSE);
        else if (!seen)         go(PH_WAIT);
        else if (age + 1 == LS) begin
          fails = 0;
          go(PH_RUN);
        end else                age++;
      end
      PH_RUN: begin
        low_run = seen ? 0 : low_run + 1;
`ifdef PLL_SUP_GLITCH_FILTER_EN
        lost = (low_run >= GC);
`else
        lost = (low_run >= 1);
`endif
        if (force_relock || lost) begin
          events = (events < 255) ? events + 1 : 255;
          go(PH_PULSE);
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge sys_clk);
      model_step();
      model_live = 1'b1;
    end
  end

  // Per-cycle comparison against the model, half a cycle after the edge.
  initial begin
    logic [11:0] exp_vec;
    forever begin
      @(negedge sys_clk);
      if (model_live) begin
        exp_vec = {(ph == PH_PULSE) || (ph == PH_DEAD), ph == PH_RUN, ph == PH_RUN,
                   ph == PH_DEAD, 8'(events)};
        check("cycle_model", {20'd0, pll_rst, user_rst_n, pll_ready, fault, relock_cnt},
              {20'd0, exp_vec});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change and outputs are sampled 2 time units
  // after each rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return pll_rst;
      1:       return pll_ready;
      default: return fault;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic v, input int budget, input string name);
    int n;
    n = 0;
    while (sig(which) !== v && n < budget) begin
      tick(1);
      n++;
    end
    check(name, sig(which), v);
  endtask

  task automatic run_length(input int which, input logic v, output int n);
    n = 0;
    while (sig(which) === v && n < 5000) begin
      n++;
      tick(1);
    end
  endtask

  initial begin
    #(10 * 60000);
    errors++;
    $display("FAIL watchdog at %0t: got timeout, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int n;
    bit rst_seen;

    // Reset state
    tick(3);
    check("reset_pll_rst", pll_rst, 1);
    check("reset_user_rst_n", user_rst_n, 0);
    check("reset_pll_ready", pll_ready, 0);
    check("reset_fault", fault, 0);
    check("reset_relock_cnt", relock_cnt, 0);

    // Normal lock
    sys_rst_n = 1'b1;
    run_length(0, 1'b1, n);
    check("first_pulse_width", n, RP);
    tick(50);
    pll_lock = 1'b1;
    tick(1);
    run_length(1, 1'b0, n);
    check("ready_latency", n, 2 + LS);
    check("run_user_rst_n", user_rst_n, 1);
    check("run_relock_cnt", relock_cnt, 0);

    // Lock loss in RUN
`ifdef PLL_SUP_GLITCH_FILTER_EN
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(10);
    check("glitch_ignored_ready", pll_ready, 1);
    check("glitch_ignored_relock", relock_cnt, 0);
    pll_lock = 1'b0;
    tick(GC);
    pll_lock = 1'b1;
`else
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
`endif
    wait_for(0, 1'b1, 10, "loss_pulse_start");
    run_length(0, 1'b1, n);
    check("loss_pulse_width", n, RP);
    check("loss_relock_cnt", relock_cnt, 1);
    check("loss_user_rst_n", user_rst_n, 0);
    wait_for(1, 1'b1, 200, "loss_rerun");

    // Force on the same cycle synchronised lock falls: one event
    pll_lock = 1'b0;
    tick(2);
    force_relock = 1'b1;
    tick(1);
    force_relock = 1'b0;
    check("simul_pll_rst", pll_rst, 1);
    check("simul_relock_cnt", relock_cnt, 2);
    wait_for(0, 1'b0, 40, "simul_pulse_end");
    tick(5);

    // Unstable lock: short high, short low, then high for good
    rst_seen = 1'b0;
    pll_lock = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      rst_seen = rst_seen | (pll_rst === 1'b1);
    end
    pll_lock = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      rst_seen = rst_seen | (pll_rst === 1'b1);
    end
    pll_lock = 1'b1;
    tick(1);
    n = 0;
    while (pll_ready !== 1'b1 && n < 500) begin
      rst_seen = rst_seen | (pll_rst === 1'b1);
      n++;
      tick(1);
    end
    check("unstable_no_rst_pulse", rst_seen, 0);
    check("unstable_ready_latency", n, 2 + LS);

    // Reset mid-operation (during STABLE)
    force_relock = 1'b1;
    tick(1);
    force_relock = 1'b0;
    check("force_relock_cnt", relock_cnt, 3);
    wait_for(0, 1'b0, 40, "force_pulse_end");
    tick(5);
    sys_rst_n = 1'b0;
    tick(1);
    check("midrst_pll_rst", pll_rst, 1);
    check("midrst_user_rst_n", user_rst_n, 0);
    check("midrst_pll_ready", pll_ready, 0);
    check("midrst_fault", fault, 0);
    check("midrst_relock_cnt", relock_cnt, 0);
    sys_rst_n = 1'b1;
    run_length(0, 1'b1, n);
    check("midrst_pulse_width", n, RP);
    wait_for(1, 1'b1, 200, "midrst_ready");

    // Timeout / retry / fault
    pll_lock = 1'b0;
    force_relock = 1'b1;
    tick(1);
    force_relock = 1'b0;
    check("timeout_relock_cnt", relock_cnt, 1);
    for (int k = 0; k < MR; k++) begin
      run_length(0, 1'b1, n);
      check("retry_pulse_width", n, RP);
      check("retry_no_fault", fault, 0);
      run_length(0, 1'b0, n);
      check("retry_gap", n, LT);
    end
    check("fault_set", fault, 1);
    check("fault_pll_rst", pll_rst, 1);
    tick(20);
    force_relock = 1'b1;
    tick(1);
    force_relock = 1'b0;
    tick(20);
    check("fault_sticky", fault, 1);
    check("fault_pll_rst_held", pll_rst, 1);
    check("fault_force_ignored", relock_cnt, 1);
    check("fault_not_ready", pll_ready, 0);

    // Saturation of relock_cnt
    sys_rst_n = 1'b0;
    tick(2);
    check("sat_reset_fault", fault, 0);
    check("sat_reset_relock", relock_cnt, 0);
    sys_rst_n = 1'b1;
    pll_lock = 1'b1;
    wait_for(1, 1'b1, 200, "sat_first_ready");
    for (int i = 0; i < 300; i++) begin
      pll_lock = 1'b0;
      tick(2);
      force_relock = 1'b1;
      tick(1);
      force_relock = 1'b0;
      pll_lock = 1'b1;
      if (i < 3 || i >= 252) check("sat_step", relock_cnt, (i + 1 > 255) ? 255 : i + 1);
      wait_for(1, 1'b1, 200, "sat_ready");
    end
    check("sat_final", relock_cnt, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
